// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - types, state encoding and op helpers for the EX->MEM memory stage.
package memory_pkg;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW,
        MEM_SB, MEM_SH, MEM_SW, MEM_LWL, MEM_LWR, MEM_SWL, MEM_SWR
    } mem_op_t;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} mem_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  writereg;
        logic [31:0] aluout;
        logic [31:0] writedata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pcplus4;
        logic        in_delay_slot;
        mem_op_t     mem_op;
        logic        exception_instr;
        logic        exception_ri;
        logic        exception_ov;
        logic        exception_syscall;
        logic        exception_break;
        logic [31:0] badvaddr;
    } execute_data_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  writereg;
        logic [31:0] result;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pcplus4;
        logic        in_delay_slot;
        logic        exception_instr;
        logic        exception_ri;
        logic        exception_ov;
        logic        exception_syscall;
        logic        exception_break;
        logic        exception_adel;
        logic        exception_ades;
        logic [31:0] badvaddr;
    } memory_data_t;

    function automatic logic is_store(mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW, MEM_SWL, MEM_SWR};
    endfunction

    function automatic logic is_lwlr(mem_op_t op);
        return op inside {MEM_LWL, MEM_LWR, MEM_SWL, MEM_SWR};
    endfunction

    function automatic logic [1:0] op_size(mem_op_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return SIZE_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: return SIZE_HALF;
            default:                 return SIZE_WORD;
        endcase
    endfunction

    // Unaligned LWL/LWR/SWL/SWR are word accesses by construction, never misaligned.
    function automatic logic misaligned(mem_op_t op, logic [1:0] a);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return a[0];
            MEM_LW, MEM_SW:          return a != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// rtl/memory_stage_load_align.sv - load lane shift, extension and LWL/LWR merge (MEM_LWLR_EN).
module load_align
    import memory_pkg::*;
(
    input  mem_op_t     mem_op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] rt_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;
    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        result_o = shifted;
        case (mem_op_i)
            MEM_LB:  result_o = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LBU: result_o = {24'b0, shifted[7:0]};
            MEM_LH:  result_o = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LHU: result_o = {16'b0, shifted[15:0]};
            MEM_LW:  result_o = rdata_i;
`ifdef MEM_LWLR_EN
            MEM_LWL: begin
                case (addr_lo_i)
                    2'd0:    result_o = {rdata_i[7:0],  rt_i[23:0]};
                    2'd1:    result_o = {rdata_i[15:0], rt_i[15:0]};
                    2'd2:    result_o = {rdata_i[23:0], rt_i[7:0]};
                    default: result_o = rdata_i;
                endcase
            end
            MEM_LWR: begin
                case (addr_lo_i)
                    2'd0:    result_o = rdata_i;
                    2'd1:    result_o = {rt_i[31:24], rdata_i[31:8]};
                    2'd2:    result_o = {rt_i[31:16], rdata_i[31:16]};
                    default: result_o = {rt_i[31:8],  rdata_i[31:24]};
                endcase
            end
`else
            // Unsupported partial-word loads never reach the bus; leave rt untouched.
            MEM_LWL, MEM_LWR: result_o = rt_i;
`endif
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - EX->MEM consumer: address-error detection, dbus handshake, load alignment; MEM_LWLR_EN adds LWL/LWR/SWL/SWR.
module memory_stage
    import memory_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  execute_data_t     in_data,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [3:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output memory_data_t      out_data
);

    mem_state_t   state_q, state_d;
    mem_op_t      op_q, op_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    memory_data_t rec_q, rec_d;
    logic         flush_pending_q, flush_pending_d;

    memory_data_t accept_rec;
    mem_state_t   accept_state;
    logic [31:0]  rdata;
    logic [31:0]  load_result;
    logic [3:0]   strobe;
    logic [31:0]  store_data;
    logic         drain;

    assign rdata = 32'(dresp_data);
    assign drain = flush || flush_pending_q;

    load_align u_load_align (
        .mem_op_i  (op_q),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (rdata),
        .rt_i      (wdata_q),
        .result_o  (load_result)
    );

    // Decide at acceptance whether the record needs the bus at all.
    always_comb begin
        accept_rec.instr             = in_data.instr;
        accept_rec.writereg          = in_data.writereg;
        accept_rec.result            = in_data.aluout;
        accept_rec.hi                = in_data.hi;
        accept_rec.lo                = in_data.lo;
        accept_rec.pcplus4           = in_data.pcplus4;
        accept_rec.in_delay_slot     = in_data.in_delay_slot;
        accept_rec.exception_instr   = in_data.exception_instr;
        accept_rec.exception_ri      = in_data.exception_ri;
        accept_rec.exception_ov      = in_data.exception_ov;
        accept_rec.exception_syscall = in_data.exception_syscall;
        accept_rec.exception_break   = in_data.exception_break;
        accept_rec.exception_adel    = 1'b0;
        accept_rec.exception_ades    = 1'b0;
        accept_rec.badvaddr          = in_data.badvaddr;
        accept_state                 = ST_REQ;
        if (in_data.exception_instr || in_data.exception_ri || in_data.exception_ov ||
            in_data.exception_syscall || in_data.exception_break) begin
            accept_state = ST_DONE;
        end
`ifndef MEM_LWLR_EN
        else if (is_lwlr(in_data.mem_op)) begin
            accept_rec.exception_ri = 1'b1;
            accept_state            = ST_DONE;
        end
`endif
        else if (misaligned(in_data.mem_op, in_data.aluout[1:0])) begin
            accept_rec.exception_ades = is_store(in_data.mem_op);
            accept_rec.exception_adel = !is_store(in_data.mem_op);
            accept_rec.badvaddr       = in_data.aluout;
            accept_state              = ST_DONE;
        end else if (in_data.mem_op == MEM_NONE) begin
            accept_state = ST_DONE;
        end
    end

    always_comb begin
        strobe     = 4'b0000;
        store_data = wdata_q;
        case (op_q)
            MEM_SB: begin
                strobe     = 4'b0001 << addr_q[1:0];
                store_data = {4{wdata_q[7:0]}};
            end
            MEM_SH: begin
                strobe     = 4'b0011 << addr_q[1:0];
                store_data = {2{wdata_q[15:0]}};
            end
            MEM_SW: strobe = 4'b1111;
`ifdef MEM_LWLR_EN
            MEM_SWL: begin
                strobe     = 4'b1111 >> (~addr_q[1:0]);
                store_data = wdata_q >> {~addr_q[1:0], 3'b000};
            end
            MEM_SWR: begin
                strobe     = 4'b1111 << addr_q[1:0];
                store_data = wdata_q << {addr_q[1:0], 3'b000};
            end
`endif
            default: strobe = 4'b0000;
        endcase
    end

    assign in_ready    = (state_q == ST_IDLE) && !flush;
    assign dreq_valid  = (state_q == ST_REQ);
    assign dreq_addr   = ADDR_W'(addr_q);
    assign dreq_size   = op_size(op_q);
    assign dreq_strobe = dreq_valid ? strobe : 4'b0000;
    assign dreq_data   = DATA_W'(store_data);
    assign out_valid   = (state_q == ST_DONE);
    assign out_data    = rec_q;

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rec_d           = rec_q;
        flush_pending_d = flush_pending_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d    = in_data.mem_op;
                    addr_d  = in_data.aluout;
                    wdata_d = in_data.writedata;
                    rec_d   = accept_rec;
                    state_d = accept_state;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (flush) flush_pending_d = 1'b1;
                // The bus cannot retract a request, so a flushed access still drains.
                if (state_q == ST_WAIT || dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        if (drain) begin
                            state_d         = ST_IDLE;
                            flush_pending_d = 1'b0;
                        end else begin
                            state_d = ST_DONE;
                            if (!is_store(op_q)) rec_d.result = load_result;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                if (flush || out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            op_q            <= MEM_NONE;
            addr_q          <= '0;
            wdata_q         <= '0;
            rec_q           <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rec_q           <= rec_d;
            flush_pending_q <= flush_pending_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage (default build, MEM_LWLR_EN undefined).
module tb_memory_stage;
    import memory_pkg::*;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    execute_data_t in_data;
    logic          flush;
    logic          dreq_valid;
    logic [31:0]   dreq_addr;
    logic [1:0]    dreq_size;
    logic [3:0]    dreq_strobe;
    logic [31:0]   dreq_data;
    logic          dresp_addr_ok;
    logic          dresp_data_ok;
    logic [31:0]   dresp_data;
    logic          out_valid;
    logic          out_ready;
    memory_data_t  out_data;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    typedef struct packed {
        logic        chk;
        logic [31:0] result;
        logic        adel;
        logic        ades;
        logic        ri;
        logic        ov;
        logic [31:0] badvaddr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_want;
    logic mon_bad;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic exp_t mk_exp(input logic chk, input logic [31:0] result, input logic adel,
                                    input logic ades, input logic ri, input logic ov,
                                    input logic [31:0] badvaddr);
        exp_t e;
        e.chk = chk; e.result = result; e.adel = adel; e.ades = ades;
        e.ri = ri; e.ov = ov; e.badvaddr = badvaddr;
        return e;
    endfunction

    // Scoreboard consumer: every writeback handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_out got result=%h, no record expected", out_data.result);
            end else begin
                mon_want = exp_q.pop_front();
                mon_bad = ({out_data.exception_adel, out_data.exception_ades, out_data.exception_ri,
                            out_data.exception_ov} !== {mon_want.adel, mon_want.ades, mon_want.ri, mon_want.ov})
                          || (out_data.badvaddr !== mon_want.badvaddr)
                          || (mon_want.chk && (out_data.result !== mon_want.result));
                if (mon_bad)
                    $display("FAIL out_record got result=%h adel=%b ades=%b ri=%b ov=%b bad=%h want result=%h(chk=%b) adel=%b ades=%b ri=%b ov=%b bad=%h",
                             out_data.result, out_data.exception_adel, out_data.exception_ades,
                             out_data.exception_ri, out_data.exception_ov, out_data.badvaddr,
                             mon_want.result, mon_want.chk, mon_want.adel, mon_want.ades,
                             mon_want.ri, mon_want.ov, mon_want.badvaddr);
                else pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd);
        in_data           = '0;
        in_data.instr     = {16'hC0DE, addr[15:0]};
        in_data.mem_op    = op;
        in_data.aluout    = addr;
        in_data.writedata = wd;
        in_data.pcplus4   = addr + 32'd4;
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
        set_rec(MEM_LW, 32'h40, 32'h0);
        tick(); tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else pass_cnt++;
        total_cnt++; if (dreq_valid !== 1'b0) $display("FAIL reset_dreq_valid got=%b want=0", dreq_valid); else pass_cnt++;
        total_cnt++; if (dreq_strobe !== 4'b0) $display("FAIL reset_strobe got=%b want=0000", dreq_strobe); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL reset_out_data got=%h want=0", out_data); else pass_cnt++;
        in_valid = 1'b0;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        set_rec(MEM_LW, 32'h8000_0004, 32'h0);
        exp_q.push_back(mk_exp(1'b1, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0));
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        total_cnt++; if ({dreq_valid, dreq_size, dreq_strobe} !== {1'b1, 2'd2, 4'b0000})
            $display("FAIL lw_req got valid=%b size=%0d strobe=%b want 1/2/0000", dreq_valid, dreq_size, dreq_strobe); else pass_cnt++;
        total_cnt++; if (dreq_addr !== 32'h8000_0004) $display("FAIL lw_addr got=%h want=80000004", dreq_addr); else pass_cnt++;
        tick();
        dresp_addr_ok = 1'b1; tick(); dresp_addr_ok = 1'b0;
        total_cnt++; if (dreq_valid !== 1'b0) $display("FAIL lw_wait_dreq got=%b want=0", dreq_valid); else pass_cnt++;
        tick();
        dresp_data_ok = 1'b1; dresp_data = 32'hDEAD_BEEF;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL lw_early_out got=%b want=0", out_valid); else pass_cnt++;
        tick(); dresp_data_ok = 1'b0; dresp_data = '0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL lw_latency got=%b want=1", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL lw_back_idle got=%b want=1", in_ready); else pass_cnt++;
    endtask

    task automatic test_sb();
        set_rec(MEM_SB, 32'h0000_1003, 32'h0000_00A5);
        exp_q.push_back(mk_exp(1'b0, 32'h0, 0, 0, 0, 0, 32'h0));
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        total_cnt++; if ({dreq_valid, dreq_size, dreq_strobe} !== {1'b1, 2'd0, 4'b1000})
            $display("FAIL sb_req got valid=%b size=%0d strobe=%b want 1/0/1000", dreq_valid, dreq_size, dreq_strobe); else pass_cnt++;
        total_cnt++; if (dreq_data !== 32'hA5A5_A5A5) $display("FAIL sb_data got=%h want=a5a5a5a5", dreq_data); else pass_cnt++;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
        tick(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        total_cnt++; if ({out_valid, dreq_valid} !== 2'b10) $display("FAIL sb_done got out=%b req=%b want 1/0", out_valid, dreq_valid); else pass_cnt++;
        tick();
        set_rec(MEM_SH, 32'h0000_1002, 32'h1234_BEEF);
        exp_q.push_back(mk_exp(1'b0, 32'h0, 0, 0, 0, 0, 32'h0));
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        total_cnt++; if ({dreq_strobe, dreq_data} !== {4'b1100, 32'hBEEF_BEEF})
            $display("FAIL sh_lanes got strobe=%b data=%h want 1100/beefbeef", dreq_strobe, dreq_data); else pass_cnt++;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
        tick(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        tick();
    endtask

    task automatic test_no_request();
        mem_op_t     ops  [4] = '{MEM_LH, MEM_SW, MEM_LWL, MEM_LW};
        logic [31:0] addrs[4] = '{32'h2001, 32'h2002, 32'h4001, 32'h4000};
        exp_t        exps [4];
        exps[0] = mk_exp(1'b0, 32'h0, 1, 0, 0, 0, 32'h2001);
        exps[1] = mk_exp(1'b0, 32'h0, 0, 1, 0, 0, 32'h2002);
        exps[2] = mk_exp(1'b0, 32'h0, 0, 0, 1, 0, 32'h0);
        exps[3] = mk_exp(1'b0, 32'h0, 0, 0, 0, 1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_rec(ops[i], addrs[i], 32'h0);
            if (i == 3) in_data.exception_ov = 1'b1;
            exp_q.push_back(exps[i]);
            in_valid = 1'b1; tick(); in_valid = 1'b0;
            total_cnt++; if ({dreq_valid, out_valid} !== 2'b01)
                $display("FAIL no_req_%0d got req=%b out=%b want 0/1", i, dreq_valid, out_valid); else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_load_extend();
        mem_op_t     ops [5] = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LB};
        logic [31:0] adr [5] = '{32'h3002, 32'h3002, 32'h3002, 32'h3002, 32'h3003};
        logic [31:0] rd  [5] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000, 32'h7F12_3456};
        logic [31:0] want[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F};
        logic [1:0]  sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 5; i++) begin
            set_rec(ops[i], adr[i], 32'h0);
            exp_q.push_back(mk_exp(1'b1, want[i], 0, 0, 0, 0, 32'h0));
            in_valid = 1'b1; tick(); in_valid = 1'b0;
            total_cnt++; if ({dreq_valid, dreq_size, dreq_strobe} !== {1'b1, sz[i], 4'b0000})
                $display("FAIL load_req_%0d got valid=%b size=%0d strobe=%b want 1/%0d/0000", i, dreq_valid, dreq_size, dreq_strobe, sz[i]); else pass_cnt++;
            dresp_addr_ok = 1'b1; tick(); dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b1; dresp_data = rd[i];
            tick(); dresp_data_ok = 1'b0; dresp_data = '0;
            tick();
        end
    endtask

    task automatic test_flush_wait();
        set_rec(MEM_LW, 32'h0000_5000, 32'h0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        dresp_addr_ok = 1'b1; tick(); dresp_addr_ok = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if ({out_valid, in_ready} !== 2'b00)
                $display("FAIL flush_wait_hold_%0d got out=%b in_ready=%b want 0/0", i, out_valid, in_ready); else pass_cnt++;
            tick();
        end
        dresp_data_ok = 1'b1; dresp_data = 32'h1111_2222;
        tick(); dresp_data_ok = 1'b0; dresp_data = '0;
        total_cnt++; if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL flush_wait_drain got out=%b in_ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
        tick();
    endtask

    task automatic test_flush_req();
        set_rec(MEM_LW, 32'h0000_6000, 32'h0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        total_cnt++; if (dreq_valid !== 1'b1) $display("FAIL flush_req_hold got=%b want=1", dreq_valid); else pass_cnt++;
        dresp_addr_ok = 1'b1; tick(); dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b1; tick(); dresp_data_ok = 1'b0;
        total_cnt++; if ({out_valid, in_ready, dreq_valid} !== 3'b010)
            $display("FAIL flush_req_drain got out=%b in_ready=%b req=%b want 0/1/0", out_valid, in_ready, dreq_valid); else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_rec(MEM_NONE, 32'h1234_5678, 32'h0);
        exp_q.push_back(mk_exp(1'b1, 32'h1234_5678, 0, 0, 0, 0, 32'h0));
        in_valid = 1'b1; tick();
        set_rec(MEM_LW, 32'h0000_7000, 32'h0);
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if ({out_valid, in_ready, dreq_valid} !== 3'b100 || out_data.result !== 32'h1234_5678 || out_data.instr !== 32'hC0DE_5678)
                $display("FAIL stall_%0d got out=%b in_ready=%b req=%b result=%h instr=%h want 1/0/0 12345678 c0de5678",
                         i, out_valid, in_ready, dreq_valid, out_data.result, out_data.instr); else pass_cnt++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        total_cnt++; if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL stall_release got out=%b in_ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            set_rec(MEM_NONE, v, 32'h0);
            exp_q.push_back(mk_exp(1'b1, v, 0, 0, 0, 0, 32'h0));
            in_valid = 1'b1; tick(); in_valid = 1'b0;
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_latency_%0d got=%b want=1", i, out_valid); else pass_cnt++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sb();
        test_no_request();
        test_load_extend();
        test_flush_wait();
        test_flush_req();
        test_backpressure();
        test_back_to_back();
        tick(); tick();
        total_cnt++; if (exp_q.size() != 0) $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
